sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning SRAM word-address width (64 KiB).
REQ-002 SHALL have port clk_i  in  1  sole clock; all flops rising-edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have instr port group: instr_req_i in 1, instr_gnt_o out 1, instr_rvalid_o out 1, instr_addr_i in 32 (byte address), instr_rdata_o out 32.
REQ-005 SHALL have data port group: data_req_i in 1, data_gnt_o out 1, data_rvalid_o out 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32 (byte address), data_wdata_i in 32, data_rdata_o out 32.
REQ-006 SHALL have SRAM port group: sram_req_o out 1 (chip enable), sram_we_o out 1, sram_be_o out 4, sram_addr_o out ADDR_W (word address), sram_wdata_o out 32, sram_rdata_i in 32 (valid exactly one cycle after an enabled read).

Function
REQ-007 SHALL grant at most one master per cycle; gnt SHALL be combinational from req in the same cycle.
REQ-008 SHALL grant the sole requester immediately; when both request, SHALL grant the master indicated by the round-robin pointer rr_q.
REQ-009 SHALL set rr_q to favour the other master after every grant; rr_q unchanged in cycles without a grant.
REQ-010 SHALL, in the grant cycle, drive sram_req_o=1 and sram_addr_o=addr[ADDR_W+1:2] of the granted master; upper address bits ignored (wrap modulo SRAM size).
REQ-011 SHALL drive sram_we_o/sram_be_o/sram_wdata_o from data port when data granted; instr grant SHALL drive sram_we_o=0, sram_be_o=4'hF.
REQ-012 SHALL register the granted-master id and return exactly one rvalid to that master per grant, one cycle after grant (base latency 1), for reads and writes alike.
REQ-013 SHALL drive instr_rdata_o and data_rdata_o from the SRAM read data; content valid only with the matching rvalid on reads; write responses carry don't-care rdata.
REQ-014 SHALL sustain back-to-back grants (one per cycle) with no bubble; the response of grant N and the grant of N+1 SHALL coexist in one cycle.
REQ-015 SHALL never assert both rvalid outputs in the same cycle.
REQ-016 SHALL hold sram_req_o=0 when no master requests.

Reset
REQ-017 SHALL on rst_i assertion immediately force all gnt, rvalid and sram_req_o outputs to 0 and rr_q to favour instr.
REQ-018 SHALL drop any response outstanding at reset assertion; no rvalid SHALL appear for it after reset.
REQ-019 SHALL drive registered rdata outputs to 32'h0 during reset (when SRAM_ARB_RSP_REG_EN defined).

Configuration
REQ-020 SHALL, with SRAM_ARB_RSP_REG_EN defined, insert an output register on rvalid and rdata: latency 2 cycles, throughput unchanged, rdata stable for the rvalid cycle.
REQ-021 SHALL, without SRAM_ARB_RSP_REG_EN, deliver rvalid combinationally from the id flop and rdata directly from sram_rdata_i (latency 1).

Structure
REQ-022 SHALL place in package sram_arb_pkg: enum master_e {MST_INSTR, MST_DATA}, constant SRAM_RD_LATENCY=1.
REQ-023 SHALL implement the two-way arbiter with rr_q as sub-module sram_arb_rr (inputs req[1:0], output gnt[1:0] one-hot or zero).

Verification
REQ-024 SHALL verify: instr only reads 0x0000_0010 holding 0xDEADBEEF -> gnt same cycle, sram_addr_o=4, instr_rvalid_o next cycle with rdata 0xDEADBEEF.
REQ-025 SHALL verify: data write addr 0x20, be=4'b0011, wdata 0x12345678, then read -> readback 0x____5678 with upper half unchanged, one data_rvalid per access.
REQ-026 SHALL verify: both request continuously 6 cycles after reset -> grants alternate I,D,I,D,I,D; rvalids alternate one cycle later, never overlapping.
REQ-027 SHALL verify: address 0x0001_0004 with ADDR_W=14 -> sram_addr_o=1 (wrap).
REQ-028 SHALL verify: rst_i asserted the cycle after a grant -> no rvalid follows; first post-reset conflict grants instr.
REQ-029 SHALL verify: REQ-024 and REQ-026 rerun with SRAM_ARB_RSP_REG_EN -> identical data, all rvalids shifted by one cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the two-master SRAM arbiter: master ids and SRAM read latency.
// No logic; imported by the arbiter core and the top level.
`timescale 1ns/1ps
package sram_arb_pkg;

  typedef enum logic {
    MST_INSTR = 1'b0,
    MST_DATA  = 1'b1
  } master_e;

  localparam int unsigned SRAM_RD_LATENCY = 1;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, rr_q flips to the other master after a grant.
// Zero latency; grants are forced low while rst_i is high.
`timescale 1ns/1ps
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  master_e rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    rr_d  = rr_q;
    if (!rst_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (rr_q == MST_INSTR) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      rr_d = MST_DATA;
    end else if (gnt_o[1]) begin
      rr_d = MST_INSTR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= MST_INSTR;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between instr and data masters; one grant per cycle, rvalid 1 cycle after grant
// (2 with SRAM_ARB_RSP_REG_EN, which registers rvalid/rdata). Losing master simply keeps req high.
`timescale 1ns/1ps
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  input  logic [31:0]       instr_addr_i,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  logic [1:0] gnt;
  logic       rsp_vld_q, rsp_vld_d;
  master_e    rsp_id_q, rsp_id_d;

  sram_arb_rr u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({data_req_i, instr_req_i}),
    .gnt_o (gnt)
  );

  assign instr_gnt_o = gnt[0];
  assign data_gnt_o  = gnt[1];

  // Address bits above the SRAM size and the byte offset are dropped, so accesses wrap.
  always_comb begin
    sram_req_o   = |gnt;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'hF;
    sram_addr_o  = instr_addr_i[ADDR_W+1:2];
    sram_wdata_o = data_wdata_i;
    rsp_vld_d    = |gnt;
    rsp_id_d     = MST_INSTR;
    if (gnt[1]) begin
      sram_we_o   = data_we_i;
      sram_be_o   = data_be_i;
      sram_addr_o = data_addr_i[ADDR_W+1:2];
      rsp_id_d    = MST_DATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= MST_INSTR;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

`ifdef SRAM_ARB_RSP_REG_EN
  logic        instr_rvalid_q, instr_rvalid_d;
  logic        data_rvalid_q, data_rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  // rdata only loads on a response so it holds steady through the rvalid cycle.
  always_comb begin
    instr_rvalid_d = rsp_vld_q && (rsp_id_q == MST_INSTR);
    data_rvalid_d  = rsp_vld_q && (rsp_id_q == MST_DATA);
    rdata_d        = rsp_vld_q ? sram_rdata_i : rdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      rdata_q        <= 32'h0;
    end else begin
      instr_rvalid_q <= instr_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      rdata_q        <= rdata_d;
    end
  end

  assign instr_rvalid_o = instr_rvalid_q;
  assign data_rvalid_o  = data_rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign data_rdata_o   = rdata_q;
`else
  assign instr_rvalid_o = rsp_vld_q && (rsp_id_q == MST_INSTR);
  assign data_rvalid_o  = rsp_vld_q && (rsp_id_q == MST_DATA);
  assign instr_rdata_o  = sram_rdata_i;
  assign data_rdata_o   = sram_rdata_i;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0],
                              data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};

endmodule
